// File: rtl/stats_pkg.sv
// Shared definitions for the statistics accumulator: default widths,
// FSM state encoding and the accumulator-width derivation.
package stats_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DIV   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ACCUM = S_ACCUM,
        ST_DIV   = S_DIV,
        ST_DONE  = S_DONE
    } state_t;

    // Sum of up to 2^cw-1 samples of dw bits never exceeds dw+cw bits.
    function automatic int sum_width(input int dw, input int cw);
        return dw + cw;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// The first iteration is folded into the load edge, so the quotient is
// registered DVD_W edges after the start cycle and o_done pulses then.
module seq_divider
    import stats_pkg::*;
#(
    parameter int DVD_W = 16,
    parameter int DVS_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quotient,
    output logic [DVS_W-1:0] o_remainder
);

    localparam int CW = $clog2(DVD_W);
    localparam logic [CW-1:0] LAST_LOAD = CW'(DVD_W - 1);

    logic [DVS_W-1:0] r_rem;
    logic [DVD_W-1:0] r_quo;
    logic [DVS_W-1:0] r_divisor;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic [DVS_W-1:0] w_src_rem;
    logic [DVD_W-1:0] w_src_quo;
    logic [DVS_W-1:0] w_dvs;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W:0]   w_trial;
    logic             w_ge;
    logic [DVS_W-1:0] w_rem_nxt;
    logic [DVD_W-1:0] w_quo_nxt;

    assign w_load = i_start & ~r_busy;

    // One restoring step; on load it works straight from the inputs.
    always_comb begin
        w_src_rem = w_load ? '0 : r_rem;
        w_src_quo = w_load ? i_dividend : r_quo;
        w_dvs     = w_load ? i_divisor : r_divisor;
        w_shift   = {w_src_rem, w_src_quo[DVD_W-1]};
        w_trial   = w_shift - {1'b0, w_dvs};
        w_ge      = (w_shift >= {1'b0, w_dvs});
        w_rem_nxt = w_ge ? w_trial[DVS_W-1:0] : w_shift[DVS_W-1:0];
        w_quo_nxt = {w_src_quo[DVD_W-2:0], w_ge};
    end

    // Iteration counter, partial remainder/quotient and handshake flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_rem     <= w_rem_nxt;
                r_quo     <= w_quo_nxt;
                r_divisor <= i_divisor;
                r_cnt     <= LAST_LOAD;
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/stats_accumulator.sv
// Collects a programmed number of unsigned samples and reports max, min
// and average. Optional macro STATS_ROUND_EN rounds the average half-up
// by biasing the dividend with count/2; timing is unchanged either way.
module stats_accumulator
    import stats_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] avg_out
);

    localparam int SUM_W = sum_width(DATA_W, CNT_W);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic [SUM_W-1:0]  r_sum;
    logic              r_first;
    logic              r_err;
    logic [DATA_W-1:0] r_max_out;
    logic [DATA_W-1:0] r_min_out;
    logic [DATA_W-1:0] r_avg_out;

    logic              w_start_ok;
    logic              w_xfer;
    logic              w_last;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [SUM_W-1:0]  w_dividend;
    logic              w_div_busy;
    logic              w_div_done;
    logic [SUM_W-1:0]  w_div_quo;
    logic [CNT_W-1:0]  w_div_rem;
    logic              w_unused;

    assign w_start_ok = (r_state == ST_IDLE) & start & (count != '0);
    assign w_xfer     = sample_valid & (r_state == ST_ACCUM);
    assign w_last     = w_xfer & (r_remaining == CNT_W'(1));
    assign w_sum_nxt  = r_sum + SUM_W'(sample);

    // The divider is launched in the cycle of the last transfer using the
    // sum that includes it, so no extra cycle is spent before dividing.
`ifdef STATS_ROUND_EN
    assign w_dividend = w_sum_nxt + SUM_W'(r_count >> 1);
`else
    assign w_dividend = w_sum_nxt;
`endif

    seq_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_start     (w_last),
        .i_dividend  (w_dividend),
        .i_divisor   (r_count),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // Quotient upper bits are zero by construction; remainder is not needed.
    assign w_unused = &{1'b0, w_div_busy, w_div_rem, w_div_quo[SUM_W-1:DATA_W]};

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_last)     w_state_nxt = ST_DIV;
            ST_DIV:   if (w_div_done) w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Set capture, running statistics and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count     <= '0;
            r_remaining <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_sum       <= '0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
            r_max_out   <= '0;
            r_min_out   <= '0;
            r_avg_out   <= '0;
        end else begin
            r_err <= (r_state == ST_IDLE) & start & (count == '0);
            if (w_start_ok) begin
                r_count     <= count;
                r_remaining <= count;
                r_sum       <= '0;
                r_first     <= 1'b1;
            end
            if (w_xfer) begin
                r_sum       <= w_sum_nxt;
                r_remaining <= r_remaining - CNT_W'(1);
                r_first     <= 1'b0;
                if (r_first || sample > r_max) r_max <= sample;
                if (r_first || sample < r_min) r_min <= sample;
            end
            if (r_state == ST_DIV && w_div_done) begin
                r_max_out <= r_max;
                r_min_out <= r_min;
                r_avg_out <= w_div_quo[DATA_W-1:0];
            end
        end
    end

    assign sample_ready = (r_state == ST_ACCUM);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign err          = r_err;
    assign max_out      = r_max_out;
    assign min_out      = r_min_out;
    assign avg_out      = r_avg_out;

endmodule

// File: tb/tb_stats_accumulator.sv
// Scoreboard bench for stats_accumulator: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_stats_accumulator;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic [7:0] count = '0;
    logic [7:0] sample = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready, busy, done, err;
    logic [7:0] max_out, min_out, avg_out;

    stats_accumulator dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .count        (count),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .max_out      (max_out),
        .min_out      (min_out),
        .avg_out      (avg_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int mx;
        int mn;
        int av;
        int cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         nchk = 0;
    int         nerr = 0;
    logic       prev_done = 1'b0;
    logic [7:0] smp[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge CLK) begin
        if (done) begin
            chk("done_single_pulse", int'(prev_done), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("max_out", int'(max_out), e.mx);
                chk("min_out", int'(min_out), e.mn);
                chk("avg_out", int'(avg_out), e.av);
                chk("done_latency", cyc, e.cyc);
            end
        end
        prev_done <= done;
    end

    task automatic do_start(input int c);
        start = 1'b1;
        count = 8'(c);
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Present one sample after 'gap' idle cycles; returns its transfer cycle.
    task automatic send(input logic [7:0] v, input int gap, output int tcyc);
        int n;
        repeat (gap) @(negedge CLK);
        sample = v;
        sample_valid = 1'b1;
        n = 0;
        while (!sample_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!sample_ready) chk("sample_ready_timeout", 0, 1);
        tcyc = cyc;
        @(negedge CLK);
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    // Back-to-back set from smp[]; expected values are pushed after the last transfer.
    task automatic run_set(input int mx, input int mn, input int av);
        int t;
        exp_t e;
        t = 0;
        do_start(smp.size());
        foreach (smp[i]) send(smp[i], 0, t);
        e.mx = mx; e.mn = mn; e.av = av; e.cyc = t + 17;
        sb.push_back(e);
        wait_drain();
    endtask

    initial begin
        int   t;
        exp_t e;
        t = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_ready", int'(sample_ready), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_err",   int'(err), 0);
        chk("rst_max",   int'(max_out), 0);
        chk("rst_min",   int'(min_out), 0);
        chk("rst_avg",   int'(avg_out), 0);

        // 1: basic set
        smp = {8'd10, 8'd20, 8'd30, 8'd41};
        run_set(41, 10, 25);

        // 2: truncation vs rounding
        smp = {8'd3, 8'd4};
`ifdef STATS_ROUND_EN
        run_set(4, 3, 4);
`else
        run_set(4, 3, 3);
`endif

        // 3: full-size set of max values
        smp.delete();
        for (int i = 0; i < 255; i++) smp.push_back(8'd255);
        run_set(255, 255, 255);

        // 4: gapped samples with an ignored mid-set start
        do_start(3);
        send(8'd7, 0, t);
        chk("busy_in_accum", int'(busy), 1);
        do_start(9);
        send(8'd200, 1, t);
        send(8'd7, 2, t);
        e.mx = 200; e.mn = 7; e.av = 71; e.cyc = t + 17;
        sb.push_back(e);
        wait_drain();

        // 5: zero count -> error pulse, results held
        chk("idle_busy", int'(busy), 0);
        do_start(0);
        chk("err_pulse", int'(err), 1);
        chk("err_busy",  int'(busy), 0);
        @(negedge CLK);
        chk("err_clear", int'(err), 0);
        chk("err_busy2", int'(busy), 0);
        chk("held_max",  int'(max_out), 200);
        chk("held_min",  int'(min_out), 7);
        chk("held_avg",  int'(avg_out), 71);

        // 6: reset mid-set, then a single-sample set
        do_start(5);
        send(8'd50, 0, t);
        send(8'd60, 0, t);
        chk("accum_ready", int'(sample_ready), 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("mid_rst_ready", int'(sample_ready), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_max",   int'(max_out), 0);
        chk("mid_rst_min",   int'(min_out), 0);
        chk("mid_rst_avg",   int'(avg_out), 0);
        repeat (20) @(negedge CLK);
        chk("no_done_after_rst", int'(sb.size()), 0);
        smp = {8'd9};
        run_set(9, 9, 9);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
